// File: rtl/id_ctrl_stage.sv
// rtl/id_ctrl_stage.sv - RV32I decode into a registered ID/EX slot with load-use bubble (optional CTRL_MEXT_EN)
module id_ctrl_stage #(
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_instr,
    input  logic [PC_W-1:0]      i_pc,
    input  logic                 i_insn_vld,
    output logic                 o_id_ready,
    input  logic                 i_flush,
    input  logic                 i_ex_ready,
    output logic                 o_ex_vld,
    output logic [PC_W-1:0]      o_pc,
    output logic [31:0]          o_instr,
    output logic [4:0]           o_rd_addr,
    output logic [21:0]          o_ctrl,
    output logic                 o_insn_legal,
    output logic [ILL_CNT_W-1:0] o_ill_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_OR    = 4'b0101,
        ALU_AND   = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    logic [3:0]  alu_op_d;
    logic [1:0]  wb_sel_d, lsu_size_d;
    logic        l_unsigned_d, op_a_sel_d, op_b_sel_d, rd_wren_d, mem_wren_d, mem_rden_d;
    logic        is_branch_d, is_jal_d, is_jalr_d, br_un_d, md_vld_d, legal_d;
    logic [21:0] ctrl_d;
    logic [4:0]  rd_d;

    always_comb begin
        alu_op_d     = ALU_ADD;
        wb_sel_d     = 2'b00;
        lsu_size_d   = 2'b00;
        l_unsigned_d = 1'b0;
        op_a_sel_d   = 1'b0;
        op_b_sel_d   = 1'b0;
        rd_wren_d    = 1'b0;
        mem_wren_d   = 1'b0;
        mem_rden_d   = 1'b0;
        is_branch_d  = 1'b0;
        is_jal_d     = 1'b0;
        is_jalr_d    = 1'b0;
        br_un_d      = 1'b0;
        md_vld_d     = 1'b0;
        legal_d      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal_d = 1'b1; alu_op_d = ALU_PASSB; op_b_sel_d = 1'b1; rd_wren_d = 1'b1;
            end
            OPC_AUIPC: begin
                legal_d = 1'b1; op_a_sel_d = 1'b1; op_b_sel_d = 1'b1; rd_wren_d = 1'b1;
            end
            OPC_JAL: begin
                legal_d = 1'b1; op_a_sel_d = 1'b1; op_b_sel_d = 1'b1; rd_wren_d = 1'b1;
                wb_sel_d = 2'b11; is_jal_d = 1'b1;
            end
            OPC_JALR: begin
                legal_d = (funct3 == 3'b000); op_b_sel_d = 1'b1; rd_wren_d = 1'b1;
                wb_sel_d = 2'b11; is_jalr_d = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU forms the target; the compare itself lives in EX
                legal_d = (funct3[2:1] != 2'b01); op_a_sel_d = 1'b1; op_b_sel_d = 1'b1;
                is_branch_d = 1'b1; br_un_d = funct3[2] & funct3[1];
            end
            OPC_LOAD: begin
                legal_d = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                op_b_sel_d = 1'b1; rd_wren_d = 1'b1; mem_rden_d = 1'b1; wb_sel_d = 2'b01;
                lsu_size_d = funct3[1:0]; l_unsigned_d = funct3[2];
            end
            OPC_STORE: begin
                legal_d = !funct3[2] && (funct3[1:0] != 2'b11);
                op_b_sel_d = 1'b1; mem_wren_d = 1'b1; lsu_size_d = funct3[1:0];
            end
            OPC_OPIMM: begin
                op_b_sel_d = 1'b1; rd_wren_d = 1'b1; alu_op_d = base_alu(funct3);
                if (funct3[1:0] != 2'b01) begin
                    legal_d = 1'b1;
                end else if (funct7 == 7'b0000000) begin
                    legal_d = 1'b1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    legal_d = 1'b1; alu_op_d = ALU_SRA;
                end
            end
            OPC_OP: begin
                rd_wren_d = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal_d = 1'b1; alu_op_d = base_alu(funct3);
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal_d = 1'b1; alu_op_d = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end
`ifdef CTRL_MEXT_EN
                else if (funct7 == 7'b0000001) begin
                    legal_d = 1'b1; md_vld_d = 1'b1; alu_op_d = ALU_ADD;
                end
`endif
            end
            default: legal_d = 1'b0;
        endcase
        ctrl_d = '0;
        if (legal_d) begin
            ctrl_d = {md_vld_d, br_un_d, is_jalr_d, is_jal_d, is_branch_d, mem_rden_d, mem_wren_d,
                      rd_wren_d, op_b_sel_d, op_a_sel_d, l_unsigned_d, lsu_size_d, wb_sel_d,
                      funct3, alu_op_d};
        end
        rd_d = ctrl_d[14] ? rd : 5'd0;
    end

    logic                 ex_vld_q, ex_vld_d;
    logic [PC_W-1:0]      pc_q;
    logic [31:0]          instr_q;
    logic [4:0]           rd_q;
    logic [21:0]          ctrl_q;
    logic                 legal_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                 adv, haz, uses_rs1, uses_rs2, accept;

    // Operand use is judged by opcode alone, so illegal encodings may stall too
    assign uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign adv    = !ex_vld_q || i_ex_ready;
    assign haz    = ex_vld_q && ctrl_q[16] && (rd_q != 5'd0) &&
                    ((uses_rs1 && rs1 == rd_q) || (uses_rs2 && rs2 == rd_q));
    assign o_id_ready = adv && !haz && !i_flush;
    assign accept     = o_id_ready && i_insn_vld;

    always_comb begin
        ex_vld_d  = ex_vld_q;
        ill_cnt_d = ill_cnt_q;
        if (i_flush) begin
            ex_vld_d = 1'b0;
        end else if (adv) begin
            ex_vld_d = accept;
        end
        if (accept && !legal_d && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_vld_q  <= 1'b0;
            pc_q      <= '0;
            instr_q   <= 32'h0000_0013;
            rd_q      <= 5'd0;
            ctrl_q    <= '0;
            legal_q   <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            ex_vld_q  <= ex_vld_d;
            ill_cnt_q <= ill_cnt_d;
            if (accept) begin
                pc_q    <= i_pc;
                instr_q <= i_instr;
                rd_q    <= rd_d;
                ctrl_q  <= ctrl_d;
                legal_q <= legal_d;
            end
        end
    end

    assign o_ex_vld     = ex_vld_q;
    assign o_pc         = pc_q;
    assign o_instr      = instr_q;
    assign o_rd_addr    = rd_q;
    assign o_ctrl       = ctrl_q;
    assign o_insn_legal = legal_q;
    assign o_ill_cnt    = ill_cnt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb/tb_id_ctrl_stage.sv - directed and random checks of id_ctrl_stage against a reference decode model
module tb_id_ctrl_stage;

`ifdef CTRL_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_instr = 32'h13;
    logic [31:0] i_pc = '0;
    logic        i_insn_vld = 1'b0, i_flush = 1'b0, i_ex_ready = 1'b1;
    logic        o_id_ready, o_ex_vld, o_insn_legal;
    logic [31:0] o_pc, o_instr;
    logic [4:0]  o_rd_addr;
    logic [21:0] o_ctrl;
    logic [1:0]  o_ill_cnt;

    id_ctrl_stage #(.PC_W(32), .ILL_CNT_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(i_instr), .i_pc(i_pc), .i_insn_vld(i_insn_vld),
        .o_id_ready(o_id_ready), .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_ex_vld(o_ex_vld),
        .o_pc(o_pc), .o_instr(o_instr), .o_rd_addr(o_rd_addr), .o_ctrl(o_ctrl),
        .o_insn_legal(o_insn_legal), .o_ill_cnt(o_ill_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Expected contents of the ID/EX slot
    logic        m_vld;
    logic [31:0] m_pc, m_instr;
    logic [4:0]  m_rd;
    logic [21:0] m_ctrl;
    logic        m_legal;
    logic [1:0]  m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {legal, ctrl}; derived from the instruction-set rules via lookup masks
    function automatic logic [22:0] ref_dec(input logic [31:0] ins);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] alu_tbl;
        logic [7:0]  ld_ok, st_ok, br_ok;
        logic [3:0]  alu;
        logic [1:0]  wb, sz;
        logic        ok, lu, a, b, wr, mw, mr, br, jal, jalr, bun, md;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        alu_tbl = 32'h6584_3270;
        ld_ok = 8'h37; st_ok = 8'h07; br_ok = 8'hF3;
        alu = 4'd0; wb = 2'd0; sz = 2'd0;
        {ok, lu, a, b, wr, mw, mr, br, jal, jalr, bun, md} = '0;
        case (op)
            7'h37: begin ok = 1; alu = 4'hA; b = 1; wr = 1; end
            7'h17: begin ok = 1; a = 1; b = 1; wr = 1; end
            7'h6F: begin ok = 1; a = 1; b = 1; wr = 1; wb = 2'd3; jal = 1; end
            7'h67: begin ok = (f3 == 3'd0); b = 1; wr = 1; wb = 2'd3; jalr = 1; end
            7'h63: begin ok = br_ok[f3]; a = 1; b = 1; br = 1; bun = (f3 >= 3'd6); end
            7'h03: begin ok = ld_ok[f3]; b = 1; wr = 1; mr = 1; wb = 2'd1; sz = f3[1:0]; lu = f3[2]; end
            7'h23: begin ok = st_ok[f3]; b = 1; mw = 1; sz = f3[1:0]; end
            7'h13: begin
                b = 1; wr = 1; alu = alu_tbl[f3*4 +: 4];
                if (f3 != 3'd1 && f3 != 3'd5) ok = 1;
                else if (f7 == 7'h00) ok = 1;
                else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; alu = alu + 4'd1; end
            end
            7'h33: begin
                wr = 1; alu = alu_tbl[f3*4 +: 4];
                if (f7 == 7'h00) ok = 1;
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin ok = 1; alu = alu + 4'd1; end
                else if (f7 == 7'h01 && MEXT) begin ok = 1; alu = 4'd0; md = 1; end
            end
            default: ok = 0;
        endcase
        if (!ok) return '0;
        return {1'b1, md, bun, jalr, jal, br, mr, mw, wr, b, a, lu, sz, wb, f3, alu};
    endfunction

    function automatic bit ref_haz(input logic [31:0] ins);
        bit reads1, reads2;
        reads1 = !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
        reads2 = (ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63);
        return m_vld && m_ctrl[16] && (m_rd != 5'd0) &&
               ((reads1 && ins[19:15] == m_rd) || (reads2 && ins[24:20] == m_rd));
    endfunction

    task automatic chk_slot(input string when);
        chk({when, ".ex_vld"}, 64'(o_ex_vld), 64'(m_vld));
        chk({when, ".pc"}, 64'(o_pc), 64'(m_pc));
        chk({when, ".instr"}, 64'(o_instr), 64'(m_instr));
        chk({when, ".rd"}, 64'(o_rd_addr), 64'(m_rd));
        chk({when, ".ctrl"}, 64'(o_ctrl), 64'(m_ctrl));
        chk({when, ".legal"}, 64'(o_insn_legal), 64'(m_legal));
        chk({when, ".ill_cnt"}, 64'(o_ill_cnt), 64'(m_cnt));
    endtask

    // Entered and left at posedge+1; asserts reset between edges to show it is asynchronous
    task automatic do_reset();
        i_insn_vld = 1'b0; i_flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_vld = 0; m_pc = '0; m_instr = 32'h13; m_rd = '0; m_ctrl = '0; m_legal = 0; m_cnt = '0;
        chk_slot("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cyc(input logic [31:0] ins, input logic [31:0] pc, input bit vld,
                       input bit fl, input bit exr);
        bit adv, haz, rdy;
        logic [22:0] dec;
        i_instr = ins; i_pc = pc; i_insn_vld = vld; i_flush = fl; i_ex_ready = exr;
        #1;
        adv = !m_vld || exr;
        haz = ref_haz(ins);
        rdy = adv && !haz && !fl;
        chk("id_ready", 64'(o_id_ready), 64'(rdy));
        @(posedge clk);
        if (fl) m_vld = 0;
        else if (adv) begin
            if (haz || !vld) m_vld = 0;
            else begin
                dec = ref_dec(ins);
                m_vld = 1; m_pc = pc; m_instr = ins;
                m_ctrl = dec[21:0]; m_legal = dec[22];
                m_rd = m_ctrl[14] ? ins[11:7] : 5'd0;
                if (!m_legal && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
            end
        end
        #1;
        chk_slot("slot");
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [6:0] op, f7;
        int k;
        k = $urandom_range(0, 12);
        case (k)
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h03;  7: op = 7'h23;
            8: op = 7'h13;  9: op = 7'h33;  10: op = 7'h33;
            11: op = 7'($urandom);
            default: return $urandom;
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        logic [1:0] cnt_before;
        @(posedge clk);
        #1;
        do_reset();

        cyc(32'h00A0_0093, 32'h100, 1, 0, 1);
        chk("addi.alu_op", 64'(o_ctrl[3:0]), 64'h0);
        chk("addi.op_b_sel", 64'(o_ctrl[13]), 64'h1);
        chk("addi.rd_wren", 64'(o_ctrl[14]), 64'h1);
        chk("addi.rd", 64'(o_rd_addr), 64'd1);
        chk("addi.legal", 64'(o_insn_legal), 64'h1);

        cyc(32'h0001_2283, 32'h104, 1, 0, 1);
        chk("lw.mem_rden", 64'(o_ctrl[16]), 64'h1);
        cyc(32'h0012_8333, 32'h108, 1, 0, 1);
        chk("haz.bubble", 64'(o_ex_vld), 64'h0);
        cyc(32'h0012_8333, 32'h108, 1, 0, 1);
        chk("add.rd", 64'(o_rd_addr), 64'd6);
        chk("add.alu_op", 64'(o_ctrl[3:0]), 64'h0);

        cyc(32'h4020_81B3, 32'h10C, 1, 0, 1);
        for (int s = 0; s < 3; s++) begin
            cyc(32'h00A0_0093, 32'h110, 1, 0, 0);
            chk("stall.alu_op", 64'(o_ctrl[3:0]), 64'h1);
        end
        cyc(32'h00A0_0093, 32'h110, 1, 0, 1);
        chk("release.pc", 64'(o_pc), 64'h110);

        cnt_before = m_cnt;
        cyc(32'hFFFF_FFFF, 32'h114, 1, 1, 1);
        chk("flush.ex_vld", 64'(o_ex_vld), 64'h0);
        chk("flush.ill_cnt", 64'(o_ill_cnt), 64'(cnt_before));

        do_reset();
        for (int s = 1; s <= 4; s++) begin
            cyc(32'hFFFF_FFFF, 32'h200 + 32'(s * 4), 1, 0, 1);
            chk("ill.legal", 64'(o_insn_legal), 64'h0);
            chk("ill.cnt", 64'(o_ill_cnt), 64'((s > 3) ? 3 : s));
        end

        do_reset();
        cyc(32'h0220_81B3, 32'h300, 1, 0, 1);
        chk("mul.legal", 64'(o_insn_legal), 64'(MEXT));
        chk("mul.md_vld", 64'(o_ctrl[21]), 64'(MEXT));
        chk("mul.ill_cnt", 64'(o_ill_cnt), MEXT ? 64'd0 : 64'd1);

        cyc(32'h0001_2283, 32'h304, 1, 0, 0);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc(rnd_ins(), $urandom, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ctrl_stage.md
Name: id_ctrl_stage

Overview:
Pipelined successor to the single-cycle decoder. Decodes RV32I, including the halfword loads/stores the single-cycle decoder lacks. Registers the control bundle into the ID/EX pipeline slot under a valid/ready handshake, and inserts a bubble on load-use hazards. Sits between the IF/ID register and the EX stage. Branch resolution moves to EX, so no br_less/br_equal inputs.

Parameters:
PC_W, 32, width of the carried program counter.
ILL_CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  reset, asynchronous, active-low.
i_instr  in  32  instruction from IF/ID.
i_pc  in  PC_W  PC of i_instr.
i_insn_vld  in  1  i_instr/i_pc valid.
o_id_ready  out  1  stage accepts i_instr this cycle.
i_flush  in  1  taken branch/jump in EX; kill slot and input.
i_ex_ready  in  1  EX accepts o_ex_vld bundle.
o_ex_vld  out  1  registered bundle valid.
o_pc  out  PC_W  registered PC.
o_instr  out  32  registered instruction (immediate generation in EX).
o_rd_addr  out  5  registered rd, forced to 0 when rd_wren=0.
o_ctrl  out  22  registered control bundle, layout below.
o_insn_legal  out  1  registered legality of the slot instruction.
o_ill_cnt  out  ILL_CNT_W  count of accepted illegal instructions.

Behaviour:
- o_ctrl layout:
  - [3:0] alu_op; [6:4] funct3; [8:7] wb_sel; [10:9] lsu_size; [11] l_unsigned.
  - [12] op_a_sel; [13] op_b_sel; [14] rd_wren; [15] mem_wren; [16] mem_rden.
  - [17] is_branch; [18] is_jal; [19] is_jalr; [20] br_un; [21] md_vld.
- alu_op encoding: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010 (used by LUI).
- wb_sel encoding: 00 ALU, 01 memory, 11 PC+4.
- lsu_size encoding: 00 byte, 01 half, 10 word.
- Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Legal branch funct3: all except 010 and 011. br_un=1 for 110 and 111.
- Any other opcode/funct3/funct7 combination is illegal: all enables in o_ctrl are 0, o_insn_legal=0.
- Reset: o_ex_vld=0, o_pc=0, o_instr=0x00000013 (NOP), o_rd_addr=0, o_ctrl=0, o_insn_legal=0, o_ill_cnt=0.
- Latency: one cycle from accept (i_insn_vld && o_id_ready) to o_ex_vld.
- Slot advance: adv = !o_ex_vld || i_ex_ready.
- Hazard: haz = o_ex_vld && mem_rden && o_rd_addr!=0 && current instruction reads that register (rs1 for all except LUI/AUIPC/JAL; rs2 for R-type/store/branch).
- o_id_ready = adv && !haz && !i_flush.
- Per-edge priority:
  1. i_flush: o_ex_vld <= 0; input dropped; counter unchanged.
  2. adv && haz: bubble, o_ex_vld <= 0; instruction held upstream.
  3. adv && i_insn_vld: load bundle, o_ex_vld <= 1.
  4. adv && !i_insn_vld: o_ex_vld <= 0.
  5. !adv: all outputs hold.
- A hazard lasts at most one cycle, since after the bubble the slot is no longer the load.
- Illegal instructions propagate with o_insn_legal=0 (EX raises the trap). o_ill_cnt increments on accept when illegal and saturates at all-ones.
- Reset asserted mid-operation clears the slot immediately; any in-flight instruction is lost.

Optional Feature:
CTRL_MEXT_EN.
- Defined: R-type with funct7=0000001 is legal; md_vld=1, alu_op=0, funct3 carries the MUL/DIV op, rd_wren=1, wb_sel=00.
- Undefined: such encodings are illegal, and md_vld is constant 0.

Test Plan:
- Reset, then accept 0x00A00093 (addi x1,x0,10) with i_ex_ready=1 -> next cycle o_ex_vld=1, o_rd_addr=1, alu_op=0000, op_b_sel=1, rd_wren=1, o_insn_legal=1.
- 0x00012283 (lw x5,0(x2)) then 0x00128333 (add x6,x5,x1) back-to-back -> one cycle with o_id_ready=0 and a bubble (o_ex_vld=0), then add issues with alu_op=0000, rd=6.
- Hold i_ex_ready=0 for 3 cycles with 0x402081B3 (sub) in slot -> o_ctrl stable, alu_op=0001, o_id_ready=0; releases on the next cycle.
- i_flush=1 with i_insn_vld=1 and a valid slot -> next cycle o_ex_vld=0, instruction not accepted, o_ill_cnt unchanged.
- Feed 0xFFFFFFFF three times with ILL_CNT_W=2 -> o_insn_legal=0 each time, o_ill_cnt reads 1, 2, 3, then stays 3 on a fourth.
- 0x022081B3 (mul): with CTRL_MEXT_EN -> md_vld=1, legal; without it -> o_insn_legal=0, o_ill_cnt+1.
